// File: rtl/param_matrix_multiplier_if.sv
// param_matrix_multiplier_if: start/operand inputs and streamed result outputs of the matrix multiplier
interface param_matrix_multiplier_if #(
  parameter int N = 2,
  parameter int ELEM_W = 4
);
  localparam int ACC_W = 2*ELEM_W + $clog2(N);
  localparam int IDX_W = (N*N > 1) ? $clog2(N*N) : 1;
  logic                    start;
  logic [N*N*ELEM_W-1:0]   matrix_a;
  logic [N*N*ELEM_W-1:0]   matrix_b;
  logic                    busy;
  logic                    result_valid;
  logic                    result_ready;
  logic [ACC_W-1:0]        result_data;
  logic [IDX_W-1:0]        result_index;
  logic                    done;
  logic [7:0]              matrix_count;
  modport master (
    output start, matrix_a, matrix_b, result_ready,
    input  busy, result_valid, result_data, result_index, done, matrix_count
  );
  modport slave (
    input  start, matrix_a, matrix_b, result_ready,
    output busy, result_valid, result_data, result_index, done, matrix_count
  );
endinterface

// File: rtl/param_matrix_multiplier.sv
// param_matrix_multiplier: NxN matrix product on one sequential MAC, results streamed row-major
module param_matrix_multiplier #(
  parameter int N = 2,
  parameter int ELEM_W = 4,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst,
  param_matrix_multiplier_if.slave bus
);
  localparam int ACC_W = 2*ELEM_W + $clog2(N);
  localparam int IDX_W = (N*N > 1) ? $clog2(N*N) : 1;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;
  localparam int M_W = N*N*ELEM_W;
  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;
  state_t            r_state;
  logic [M_W-1:0]    r_a, r_b;
  logic [K_W-1:0]    r_i, r_j, r_k;
  logic [ACC_W-1:0]  r_acc, r_data;
  logic [IDX_W-1:0]  r_index;
  logic              r_busy, r_valid, r_done;
  logic [7:0]        r_count;
  logic [ELEM_W-1:0] w_ea, w_eb;
  logic [ACC_W-1:0]  w_xa, w_xb, w_sum;
  logic              w_k_last, w_j_last, w_last;
  assign w_ea = r_a[(int'(r_i)*N + int'(r_k))*ELEM_W +: ELEM_W];
  assign w_eb = r_b[(int'(r_k)*N + int'(r_j))*ELEM_W +: ELEM_W];
  // widening first makes the truncated product exact for both signed and unsigned operands
  assign w_xa = {{(ACC_W-ELEM_W){SIGNED && w_ea[ELEM_W-1]}}, w_ea};
  assign w_xb = {{(ACC_W-ELEM_W){SIGNED && w_eb[ELEM_W-1]}}, w_eb};
  assign w_sum = r_acc + w_xa * w_xb;
  assign w_k_last = r_k == K_W'(N-1);
  assign w_j_last = r_j == K_W'(N-1);
  assign w_last = w_j_last && r_i == K_W'(N-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_a     <= bus.matrix_a;
          r_b     <= bus.matrix_b;
          r_acc   <= '0;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_busy  <= 1'b1;
          r_state <= MAC;
        end
        MAC: if (w_k_last) begin
          r_state <= EMIT;
          r_valid <= 1'b1;
          r_data  <= w_sum;
          r_index <= IDX_W'(int'(r_i)*N + int'(r_j));
        end else begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
        end
        EMIT: if (bus.result_ready) begin
          r_valid <= 1'b0;
          r_acc   <= '0;
          r_k     <= '0;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_count <= r_count + 1'b1;
          end else begin
            r_state <= MAC;
            r_j     <= w_j_last ? '0 : r_j + 1'b1;
            r_i     <= w_j_last ? r_i + 1'b1 : r_i;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.result_valid = r_valid;
  assign bus.result_data = r_data;
  assign bus.result_index = r_index;
  assign bus.done = r_done;
  assign bus.matrix_count = r_count;
endmodule

// File: doc/param_matrix_multiplier.md
Name: param_matrix_multiplier

Overview:
Parametrised successor to the fixed 2x2, 4-bit matrix multiplier. It computes C = A x B for square NxN matrices of ELEM_W-bit elements, signed or unsigned. It uses one multiply-accumulate (MAC) unit, sequenced by an internal FSM. Each result element streams out over a valid/ready interface in row-major order, and a running count of completed multiplications is kept.

Parameters:
N, 2, matrix dimension (N >= 1).
ELEM_W, 4, bit width of each input element.
SIGNED, 0, selects the arithmetic: 0 = unsigned, 1 = two's-complement signed.
ACC_W, localparam = 2*ELEM_W + clog2(N), width of each result element.
IDX_W, localparam = max(1, clog2(N*N)), width of the result index.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a multiplication; sampled only in IDLE.
matrix_A  in  N*N*ELEM_W  packed A; element (r,c) sits at bits [(r*N+c)*ELEM_W +: ELEM_W].
matrix_B  in  N*N*ELEM_W  packed B; same packing as matrix_A.
busy  out  1  high in every state except IDLE.
result_valid  out  1  a result element is presented.
result_ready  in  1  the consumer accepts the element presented.
result_data  out  ACC_W  C(i,j); sign-extended when SIGNED=1.
result_index  out  IDX_W  i*N+j of the element on result_data.
done  out  1  one-cycle pulse after the last element is accepted.
matrix_count  out  8  number of completed multiplications; wraps from 255 to 0.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State goes to IDLE; accumulator, k, i and j are cleared.
  - busy, result_valid, done, result_data, result_index and matrix_count all go to 0.
  - Reset takes priority over every other input in the same cycle.
- IDLE: start=1 latches matrix_A and matrix_B into internal registers, clears the accumulator, sets i=j=k=0 and moves to MAC.
  - After this edge, changes on the input buses have no effect until the next start.
- MAC: each cycle, acc += A(i,k)*B(k,j), then k increments.
  - After N cycles (k = N-1 processed), move to EMIT.
  - Products and the accumulator are ACC_W wide and sign- or zero-extended per SIGNED; overflow is impossible by construction.
- EMIT: result_valid=1, result_data=acc, result_index=i*N+j.
  - While result_ready=0, all three outputs hold stable and the state holds.
  - On the cycle with result_ready=1 (the transfer), move to the next element in row-major order: clear acc, set k=0, go to MAC.
  - If the transfer was element N*N-1, go to DONE instead.
- DONE: done=1 for exactly one cycle; matrix_count increments (255 wraps to 0); move to IDLE.
- result_valid is 0 in every state other than EMIT. result_data and result_index hold their last value outside EMIT.
- start is ignored whenever busy=1, including during the DONE cycle; it is not queued.
- Latency with result_ready tied high, start sampled at cycle 0:
  - first result_valid at cycle N+1;
  - element e presented at cycle (e+1)*(N+1);
  - done at cycle N*N*(N+1)+1 (cycle 13 for N=2).
- Each cycle result_ready is low during EMIT adds one cycle of delay to all later events.
- Reset mid-operation aborts the job immediately: no done pulse, matrix_count unchanged by the aborted job (it is cleared by reset anyway), outputs at reset values on the next cycle.
- N=1: one MAC cycle, then one EMIT; IDX_W=1 and result_index is always 0.

Test Plan:
- N=2, ELEM_W=4, SIGNED=0, matrix_A=16'h4321, matrix_B=16'h8765, start pulse, ready tied 1 -> results 19, 22, 43, 50 at indices 0..3 on cycles 3, 6, 9, 12; done on cycle 13; matrix_count=1.
- Unsigned maximum: all elements 4'hF -> four results of 450 (ACC_W=9), no wrap.
- SIGNED=1, all elements 4'h8 (-8) -> four results of 9'd128. Second run: A elements all 4'h7, B elements all 4'h8 -> four results of -112 (9'h190).
- Backpressure: result_ready=0 for 5 cycles while element 1 is presented -> result_valid, data (22) and index (1) held stable; done delayed to cycle 18.
- start pulsed during MAC and during the DONE cycle, with different matrix_A -> ignored; results match the originally latched operands; matrix_count increments only once.
- reset asserted during EMIT of element 2 -> next cycle: busy=0, result_valid=0, matrix_count=0, no done. A fresh start then completes normally. Also: 256 back-to-back jobs -> matrix_count wraps to 0.
